// File: rtl/magnitude_squared_cal_pkg.sv
// Shared constants, state type and helpers for the I^2 + Q^2 unit and its sqrt consumer.
// MAG_SQ_RADIX4_EN selects two multiplier bits per iteration instead of one.
package magnitude_squared_cal_pkg;

    localparam int DATA_WIDTH_DEF   = 71;
    localparam int MAG_SQ_OUT_WIDTH = 2 * DATA_WIDTH_DEF;
    localparam int ITER_CNT_W       = $clog2(DATA_WIDTH_DEF);

`ifdef MAG_SQ_RADIX4_EN
    localparam int RADIX_BITS = 2;
`else
    localparam int RADIX_BITS = 1;
`endif

    typedef enum logic [1:0] {
        IDLE,
        SQ_I,
        SQ_Q,
        DONE
    } mag_sq_state_e;

    // Iterations needed to consume a dw-bit multiplier at RADIX_BITS bits per step.
    function automatic int iter_count(input int dw);
        return (dw + RADIX_BITS - 1) / RADIX_BITS;
    endfunction

endpackage

// File: rtl/magnitude_squared_cal_square_accum_step.sv
// One shift-add squaring step: acc_o = acc_i + (digit * operand) << shift.
// The digit covers radix-2 (0/1) and radix-4 (0..3) so one adder serves both builds.
module square_accum_step #(
    parameter int DW = 71,
    parameter int AW = 142,
    parameter int SW = 8
) (
    input  logic [DW-1:0] op_i,
    input  logic [DW+1:0] op3_i,
    input  logic [1:0]    digit_i,
    input  logic [SW-1:0] shift_i,
    input  logic [AW-1:0] acc_i,
    output logic [AW-1:0] acc_o
);
    localparam int EW = DW + 2;

    logic [EW-1:0] addend;

    always_comb begin
        addend = '0;
        unique case (digit_i)
            2'd1:    addend = EW'(op_i);
            2'd2:    addend = EW'({op_i, 1'b0});
            2'd3:    addend = op3_i;
            default: addend = '0;
        endcase
        acc_o = acc_i + (AW'(addend) << shift_i);
    end

endmodule

// File: rtl/magnitude_squared_cal.sv
// Iterative I^2 + Q^2 with valid/ready handshakes; one shared accumulator adder.
// Define MAG_SQ_RADIX4_EN for two multiplier bits per cycle (same results, half latency).
module magnitude_squared_cal
    import magnitude_squared_cal_pkg::*;
#(
    parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
    localparam int OUT_WIDTH  = 2 * DATA_WIDTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic signed [DATA_WIDTH-1:0] inputI,
    input  logic signed [DATA_WIDTH-1:0] inputQ,
    output logic                         ready,
    output logic                         outputValid,
    input  logic                         outputReady,
    output logic        [OUT_WIDTH-1:0]  outputData
);
    localparam int         ITERS      = iter_count(DATA_WIDTH);
    localparam int         MULT_W     = ITERS * RADIX_BITS;
    localparam int         CNT_W      = $clog2(DATA_WIDTH);
    localparam int         SH_W       = $clog2(OUT_WIDTH);
    localparam logic [1:0] DIGIT_MASK = (RADIX_BITS == 2) ? 2'b11 : 2'b01;

    mag_sq_state_e         state_q;
    logic [DATA_WIDTH-1:0] abs_i_q, abs_q_q, abs_i_d, abs_q_d;
    logic [OUT_WIDTH-1:0]  acc_q, acc_d, data_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  accept, last;

    logic [DATA_WIDTH-1:0] op;
    logic [DATA_WIDTH+1:0] op3;
    logic [MULT_W-1:0]     mult;
    logic [SH_W-1:0]       shift;
    logic [1:0]            digit;

    // Magnitudes as unsigned; the most negative value maps to 2^(W-1), which still fits.
    assign abs_i_d = inputI[DATA_WIDTH-1] ? $unsigned(-inputI) : $unsigned(inputI);
    assign abs_q_d = inputQ[DATA_WIDTH-1] ? $unsigned(-inputQ) : $unsigned(inputQ);

    assign ready       = (state_q == IDLE) || ((state_q == DONE) && outputReady);
    assign accept      = enable && ready;
    assign outputValid = (state_q == DONE);
    assign outputData  = data_q;

    assign op    = (state_q == SQ_Q) ? abs_q_q : abs_i_q;
    assign mult  = MULT_W'(op);
    assign shift = SH_W'(cnt_q) * SH_W'(RADIX_BITS);
    assign digit = 2'(mult >> shift) & DIGIT_MASK;
    assign last  = (cnt_q == CNT_W'(ITERS - 1));

`ifdef MAG_SQ_RADIX4_EN
    logic [DATA_WIDTH+1:0] op3_i_q, op3_q_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            op3_i_q <= '0;
            op3_q_q <= '0;
        end else if (accept) begin
            op3_i_q <= {abs_i_d, 1'b0} + (DATA_WIDTH + 2)'(abs_i_d);
            op3_q_q <= {abs_q_d, 1'b0} + (DATA_WIDTH + 2)'(abs_q_d);
        end
    end

    assign op3 = (state_q == SQ_Q) ? op3_q_q : op3_i_q;
`else
    assign op3 = '0;
`endif

    square_accum_step #(
        .DW (DATA_WIDTH),
        .AW (OUT_WIDTH),
        .SW (SH_W)
    ) u_step (
        .op_i    (op),
        .op3_i   (op3),
        .digit_i (digit),
        .shift_i (shift),
        .acc_i   (acc_q),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            abs_i_q <= '0;
            abs_q_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        abs_i_q <= abs_i_d;
                        abs_q_q <= abs_q_d;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= SQ_I;
                    end else if (state_q == DONE && outputReady) begin
                        state_q <= IDLE;
                    end
                end
                SQ_I: begin
                    acc_q <= acc_d;
                    if (last) begin
                        cnt_q   <= '0;
                        state_q <= SQ_Q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SQ_Q: begin
                    acc_q <= acc_d;
                    if (last) begin
                        cnt_q   <= '0;
                        data_q  <= acc_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
